// File: rtl/cmp_sampler.sv
// cmp_sampler: strobe-timed comparator sampler.
// Counts comparator hits over a run of strobe edges.
module cmp_sampler #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int SETTLE_WIDTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stb_i,
  input  logic                    stb_rdy_i,
  input  logic                    cmp_i,
  input  logic                    start_i,
  input  logic [CNT_WIDTH-1:0]    n_samples_i,
  input  logic [SETTLE_WIDTH-1:0] settle_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [CNT_WIDTH-1:0]    hits_o,
  output logic [CNT_WIDTH-1:0]    total_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, WAIT_STB, SETTLE, DONE
  } state_t;

  state_t state_q, state_d;

  logic                    stb_q;
  logic                    cmp_m_q, cmp_s_q;
  logic [CNT_WIDTH-1:0]    n_q, n_d;
  logic [SETTLE_WIDTH-1:0] set_q, set_d;
  logic [SETTLE_WIDTH-1:0] scnt_q, scnt_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]    hits_q, hits_d;
  logic [CNT_WIDTH-1:0]    total_q, total_d;
  logic                    err_q, err_d;
  logic [CNT_WIDTH-1:0]    hits_o_q, hits_o_d;
  logic [CNT_WIDTH-1:0]    total_o_q, total_o_d;

  logic edge_w, tmo_w, sample_w, last_w;

  assign edge_w   = stb_i & ~stb_q;
  assign tmo_w    = (tmo_q == TMO_LAST);
  assign sample_w = (scnt_q == '0);
  assign last_w   = ((total_q + 1'b1) == n_q);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; an edge wins over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (!stb_rdy_i || n_samples_i == '0)
            state_d = DONE;
          else
            state_d = WAIT_STB;
        end
      end
      WAIT_STB: begin
        if (!stb_rdy_i)  state_d = DONE;
        else if (edge_w) state_d = SETTLE;
        else if (tmo_w)  state_d = DONE;
      end
      SETTLE: begin
        if (sample_w)
          state_d = last_w ? DONE : WAIT_STB;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state and result registers
  always_comb begin
    busy_o  = (state_q == WAIT_STB) || (state_q == SETTLE);
    done_o  = (state_q == DONE);
    err_o   = err_q;
    hits_o  = hits_o_q;
    total_o = total_o_q;
  end

  // Datapath next-state: capture, settle/timeout counting, sampling
  always_comb begin
    n_d     = n_q;
    set_d   = set_q;
    scnt_d  = scnt_q;
    tmo_d   = tmo_q;
    hits_d  = hits_q;
    total_d = total_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          n_d     = n_samples_i;
          set_d   = settle_i;
          scnt_d  = '0;
          tmo_d   = '0;
          hits_d  = '0;
          total_d = '0;
          err_d   = ~stb_rdy_i;
        end
      end
      WAIT_STB: begin
        if (!stb_rdy_i) begin
          err_d = 1'b1;
        end else if (edge_w) begin
          scnt_d = set_q;
          tmo_d  = '0;
        end else if (tmo_w) begin
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SETTLE: begin
        if (sample_w) begin
          total_d = total_q + 1'b1;
          hits_d  = hits_q + CNT_WIDTH'(cmp_s_q);
          tmo_d   = '0;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      default: ;
    endcase
    hits_o_d  = hits_o_q;
    total_o_d = total_o_q;
    if (state_d == DONE && state_q != DONE) begin
      hits_o_d  = hits_d;
      total_o_d = total_d;
    end
  end

  // Datapath, synchroniser and edge-history registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_q     <= 1'b0;
      cmp_m_q   <= 1'b0;
      cmp_s_q   <= 1'b0;
      n_q       <= '0;
      set_q     <= '0;
      scnt_q    <= '0;
      tmo_q     <= '0;
      hits_q    <= '0;
      total_q   <= '0;
      err_q     <= 1'b0;
      hits_o_q  <= '0;
      total_o_q <= '0;
    end else begin
      stb_q     <= stb_i;
      cmp_m_q   <= cmp_i;
      cmp_s_q   <= cmp_m_q;
      n_q       <= n_d;
      set_q     <= set_d;
      scnt_q    <= scnt_d;
      tmo_q     <= tmo_d;
      hits_q    <= hits_d;
      total_q   <= total_d;
      err_q     <= err_d;
      hits_o_q  <= hits_o_d;
      total_o_q <= total_o_d;
    end
  end

endmodule

// File: tb/tb_cmp_sampler.sv
// tb_cmp_sampler: randomized and directed runs
// against an event-level reference model.
module tb_cmp_sampler;

  localparam int CW   = 16;
  localparam int SW   = 8;
  localparam int TMO  = 64;
  localparam int MAXC = 4096;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          stb_i;
  logic          stb_rdy_i;
  logic          cmp_i;
  logic          start_i;
  logic [CW-1:0] n_samples_i;
  logic [SW-1:0] settle_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [CW-1:0] hits_o;
  logic [CW-1:0] total_o;

  int checks = 0;
  int errors = 0;

  bit stb_a [MAXC];
  bit cmp_a [MAXC];
  bit rdy_a [MAXC];

  cmp_sampler #(
    .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TMO),
    .SETTLE_WIDTH(SW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .stb_i(stb_i),
    .stb_rdy_i(stb_rdy_i),
    .cmp_i(cmp_i),
    .start_i(start_i),
    .n_samples_i(n_samples_i),
    .settle_i(settle_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .hits_o(hits_o),
    .total_o(total_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Strobe of period p, high for hw cycles from phase ph,
  // at most ne rising edges (ne<0: unlimited).
  // cmp mode 0: constant 1, 1: toggles per strobe, 2: random
  task automatic gen(input int p, input int hw,
                     input int ph, input int ne,
                     input int mode);
    int cnt = 0;
    for (int i = 0; i < MAXC; i++) begin
      rdy_a[i] = 1'b1;
      stb_a[i] = 1'b0;
      if (i >= ph && (i - ph) % p < hw) begin
        if ((i - ph) % p == 0) cnt++;
        stb_a[i] = (ne < 0) || (cnt <= ne);
      end
      unique case (mode)
        0: cmp_a[i] = 1'b1;
        1: cmp_a[i] = (i < ph) ? 1'b1 :
                      (((i - ph) / p) % 2 == 0);
        default: cmp_a[i] = 1'($urandom);
      endcase
    end
  endtask

  // Reference: cycle 0 carries start. Every WAIT window
  // opens at cycle w; the first rising edge c within
  // TMO cycles is taken, its sample sees cmp from cycle
  // c+st-1 (two-flop sync), and WAIT reopens at c+st+2.
  function automatic void model(input int n, input int st,
                                output int tot,
                                output int hits,
                                output int err,
                                output int dn);
    int w = 1;
    int c;
    bit got;
    tot = 0; hits = 0; err = 0; dn = MAXC;
    if (!rdy_a[0]) begin err = 1; dn = 1; return; end
    if (n == 0) begin dn = 1; return; end
    while (w < MAXC - 100) begin
      got = 1'b0;
      for (c = w; c < w + TMO; c++) begin
        if (!rdy_a[c]) begin
          err = 1; dn = c + 1; return;
        end
        if (stb_a[c] && !stb_a[c-1]) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin err = 1; dn = w + TMO; return; end
      tot++;
      hits += int'(cmp_a[c + st - 1]);
      w = c + st + 2;
      if (tot == n) begin dn = w; return; end
    end
  endfunction

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      start_i = 1'b0; stb_i = 1'b0;
      stb_rdy_i = 1'b1; cmp_i = 1'b0;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic run(input int n, input int st,
                     input string tag);
    int et, eh, ee, ed;
    int pulses = 0;
    int dcyc = -1;
    logic busy1 = 1'b0;
    logic busyd = 1'b1;
    model(n, st, et, eh, ee, ed);
    for (int i = 0; i < ed + 3; i++) begin
      rst_i = 1'b0;
      start_i = (i == 0);
      n_samples_i = CW'(n);
      settle_i = SW'(st);
      stb_i = stb_a[i];
      cmp_i = cmp_a[i];
      stb_rdy_i = rdy_a[i];
      @(posedge clk_i); #1;
      if (i == 0) busy1 = busy_o;
      if (done_o === 1'b1) begin
        pulses++;
        dcyc = i + 1;
        busyd = busy_o;
      end
    end
    check({tag, ".pulses"}, pulses, 1);
    check({tag, ".done_cyc"}, dcyc, ed);
    check({tag, ".busy_run"}, busy1, (ed > 1));
    check({tag, ".busy_done"}, busyd, 0);
    check({tag, ".total"}, total_o, et);
    check({tag, ".hits"}, hits_o, eh);
    check({tag, ".err"}, err_o, ee);
    idle(3);
    check({tag, ".total_hold"}, total_o, et);
  endtask

  initial begin
    int p, hw, ph, n, st, ne;
    rst_i = 1'b1; start_i = 1'b0; stb_i = 1'b0;
    stb_rdy_i = 1'b1; cmp_i = 1'b0;
    n_samples_i = '0; settle_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.busy", busy_o, 0);
    check("rst.done", done_o, 0);
    check("rst.err", err_o, 0);
    check("rst.hits", hits_o, 0);
    check("rst.total", total_o, 0);
    rst_i = 1'b0;

    gen(20, 1, 3, -1, 0);
    run(4, 3, "basic");

    gen(20, 10, 3, -1, 1);
    run(8, 3, "toggle");

    gen(10, 1, 2, 2, 0);
    run(5, 3, "timeout");

    gen(10, 1, 2, -1, 0);
    run(0, 3, "nzero");

    gen(10, 1, 2, -1, 0);
    rdy_a[0] = 1'b0;
    run(4, 3, "not_rdy");

    gen(3, 1, 1, -1, 2);
    run(6, 5, "fast_stb");

    gen(9, 3, 2, -1, 2);
    for (int i = 40; i < MAXC; i++) rdy_a[i] = 1'b0;
    run(10, 2, "rdy_drop");

    gen(10, 1, 2, -1, 0);
    run(3, 1, "pre_rst");
    for (int i = 0; i < 25; i++) begin
      start_i = (i == 0);
      n_samples_i = CW'(5);
      settle_i = SW'(4);
      stb_i = stb_a[i];
      cmp_i = cmp_a[i];
      stb_rdy_i = 1'b1;
      rst_i = (i == 24);
      @(posedge clk_i); #1;
    end
    check("midrst.busy", busy_o, 0);
    check("midrst.done", done_o, 0);
    check("midrst.err", err_o, 0);
    check("midrst.hits", hits_o, 0);
    check("midrst.total", total_o, 0);
    gen(7, 2, 1, -1, 2);
    run(2, 2, "after_rst");

    for (int r = 0; r < 12; r++) begin
      p  = $urandom_range(2, 30);
      hw = $urandom_range(1, p - 1);
      ph = $urandom_range(1, p);
      n  = $urandom_range(1, 12);
      st = $urandom_range(0, 20);
      ne = ($urandom_range(0, 3) == 0) ?
           $urandom_range(0, n) : -1;
      gen(p, hw, ph, ne, 2);
      if ($urandom_range(0, 4) == 0) begin
        int k = $urandom_range(5, 200);
        for (int i = k; i < MAXC; i++) rdy_a[i] = 1'b0;
      end
      run(n, st, $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
